// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one instruction-memory read port between the
// fetch unit (F) and an auxiliary reader (A). One outstanding request at a
// time, round-robin on ties; a branch redirect squashes fetch responses.
// Optional response timeout enabled by defining IMEM_PORT_ARBITER_TIMEOUT_EN.
module imem_port_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int INSN_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] f_addr_i,
    input  logic                  f_en_i,
    output logic                  f_busy_o,
    output logic                  f_gnt_o,
    output logic                  f_rdy_o,
    output logic [INSN_WIDTH-1:0] f_data_o,
    input  logic [DATA_WIDTH-1:0] a_addr_i,
    input  logic                  a_en_i,
    output logic                  a_busy_o,
    output logic                  a_gnt_o,
    output logic                  a_rdy_o,
    output logic [INSN_WIDTH-1:0] a_data_o,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic                  mem_en_o,
    input  logic [INSN_WIDTH-1:0] mem_data_i,
    input  logic                  mem_valid_i,
    output logic                  err_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
    typedef enum logic {OWN_F = 1'b0, OWN_A = 1'b1} owner_t;

    state_t                r_state;
    state_t                w_next;
    owner_t                r_owner;
    owner_t                r_last_gnt;
    logic                  r_squash;
    logic                  r_mem_en;
    logic [DATA_WIDTH-1:0] r_mem_addr;

    logic w_cand_f;
    logic w_cand_a;
    logic w_gnt_f;
    logic w_gnt_a;
    logic w_kill;
    logic w_timeout;

    // A fetch request in the same cycle as a redirect is stale; never grant it.
    assign w_cand_f = f_en_i && !flush_i;
    assign w_cand_a = a_en_i;
    // On a tie the port that did not win last time goes first.
    assign w_gnt_f  = (r_state == S_IDLE) && w_cand_f && (!w_cand_a || (r_last_gnt == OWN_A));
    assign w_gnt_a  = (r_state == S_IDLE) && w_cand_a && (!w_cand_f || (r_last_gnt == OWN_F));

    // A fetch response is dropped if a redirect arrived at any point since issue,
    // including the very cycle the data returns.
    assign w_kill   = r_squash || (flush_i && (r_owner == OWN_F));

`ifdef IMEM_PORT_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;

    // Wait-cycle counter: zeroed while issuing, so it reads 0 on the first WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // A response arriving on the limit cycle still completes normally.
    assign w_timeout = (r_state == S_WAIT) && (r_cnt == CW'(TIMEOUT)) && !mem_valid_i;
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Grant bookkeeping, squash tracking and the registered memory request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner    <= OWN_F;
            r_last_gnt <= OWN_A;
            r_squash   <= 1'b0;
            r_mem_en   <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_mem_en <= 1'b0;
            if (w_gnt_f || w_gnt_a) begin
                r_owner    <= w_gnt_f ? OWN_F : OWN_A;
                r_last_gnt <= w_gnt_f ? OWN_F : OWN_A;
                r_mem_addr <= w_gnt_f ? f_addr_i : a_addr_i;
                r_mem_en   <= 1'b1;
                r_squash   <= 1'b0;
            end else if ((r_state != S_IDLE) && flush_i && (r_owner == OWN_F)) begin
                r_squash <= 1'b1;
            end
        end
    end

    // Next state plus the combinational grant/ready pulses.
    always_comb begin
        w_next  = r_state;
        f_gnt_o = 1'b0;
        a_gnt_o = 1'b0;
        f_rdy_o = 1'b0;
        a_rdy_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                f_gnt_o = w_gnt_f;
                a_gnt_o = w_gnt_a;
                if (w_gnt_f || w_gnt_a) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (mem_valid_i) begin
                    w_next  = S_IDLE;
                    f_rdy_o = (r_owner == OWN_F) && !w_kill;
                    a_rdy_o = (r_owner == OWN_A) && !w_kill;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign f_busy_o   = (r_state != S_IDLE);
    assign a_busy_o   = (r_state != S_IDLE);
    assign f_data_o   = mem_data_i;
    assign a_data_o   = mem_data_i;
    assign mem_en_o   = r_mem_en;
    assign mem_addr_o = r_mem_addr;
    assign err_o      = w_timeout;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: inputs change 1ns after the rising
// edge, outputs are compared on the falling edge.
module tb_imem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] f_addr_i, a_addr_i;
    logic        f_en_i, a_en_i, flush_i;
    logic        f_busy_o, f_gnt_o, f_rdy_o;
    logic        a_busy_o, a_gnt_o, a_rdy_o;
    logic [31:0] f_data_o, a_data_o, mem_data_i;
    logic [63:0] mem_addr_o;
    logic        mem_en_o, mem_valid_i, err_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    imem_port_arbiter #(
        .DATA_WIDTH(64),
        .INSN_WIDTH(32),
        .TIMEOUT   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .f_addr_i   (f_addr_i),
        .f_en_i     (f_en_i),
        .f_busy_o   (f_busy_o),
        .f_gnt_o    (f_gnt_o),
        .f_rdy_o    (f_rdy_o),
        .f_data_o   (f_data_o),
        .a_addr_i   (a_addr_i),
        .a_en_i     (a_en_i),
        .a_busy_o   (a_busy_o),
        .a_gnt_o    (a_gnt_o),
        .a_rdy_o    (a_rdy_o),
        .a_data_o   (a_data_o),
        .flush_i    (flush_i),
        .mem_addr_o (mem_addr_o),
        .mem_en_o   (mem_en_o),
        .mem_data_i (mem_data_i),
        .mem_valid_i(mem_valid_i),
        .err_o      (err_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Present requests in an IDLE cycle and check the grant pulses.
    // Returns 1ns into the following cycle (ISSUE when granted).
    task automatic grant(input string tag, input logic fe, input logic [63:0] fa,
                         input logic ae, input logic [63:0] aa, input logic fl,
                         input logic ef, input logic ea);
        f_en_i = fe; f_addr_i = fa; a_en_i = ae; a_addr_i = aa; flush_i = fl;
        @(negedge clk);
        chk({tag, ".fgnt"}, f_gnt_o, ef);
        chk({tag, ".agnt"}, a_gnt_o, ea);
        chk({tag, ".idle"}, f_busy_o | a_busy_o, 0);
        tick();
        flush_i = 1'b0;
    endtask

    // Starting in ISSUE: check the memory strobe, then answer after lat WAIT
    // cycles. flush_i is raised in WAIT cycle fl_at (-1 = never).
    task automatic serve(input string tag, input logic [63:0] eaddr, input int lat,
                         input logic [31:0] d, input int fl_at,
                         input logic ef, input logic ea);
        @(negedge clk);
        chk({tag, ".men"}, mem_en_o, 1);
        chk({tag, ".maddr"}, mem_addr_o, eaddr);
        chk({tag, ".busy_iss"}, f_busy_o & a_busy_o, 1);
        tick();
        for (int k = 0; k < lat; k++) begin
            flush_i = (k == fl_at);
            if (k == lat - 1) begin
                mem_valid_i = 1'b1;
                mem_data_i  = d;
            end
            @(negedge clk);
            chk({tag, ".busy_w"}, f_busy_o & a_busy_o, 1);
            if (k == lat - 1) begin
                chk({tag, ".frdy"}, f_rdy_o, ef);
                chk({tag, ".ardy"}, a_rdy_o, ea);
                chk({tag, ".err"}, err_o, 0);
                if (ef) chk({tag, ".fdata"}, f_data_o, d);
                if (ea) chk({tag, ".adata"}, a_data_o, d);
            end else begin
                chk({tag, ".men_w"}, mem_en_o, 0);
                chk({tag, ".rdy_w"}, f_rdy_o | a_rdy_o, 0);
            end
            tick();
        end
        mem_valid_i = 1'b0;
        flush_i     = 1'b0;
        mem_data_i  = '0;
    endtask

    initial begin
        rst = 1'b1; f_addr_i = '0; a_addr_i = '0; f_en_i = 0; a_en_i = 0;
        flush_i = 0; mem_data_i = '0; mem_valid_i = 0;
        tick();
        @(negedge clk);
        chk("rst.busy", {f_busy_o, a_busy_o}, 0);
        chk("rst.men", mem_en_o, 0);
        chk("rst.maddr", mem_addr_o, 0);
        chk("rst.err", err_o, 0);
        chk("rst.gntrdy", {f_gnt_o, a_gnt_o, f_rdy_o, a_rdy_o}, 0);
        tick();
        rst = 1'b0;

        // Single fetch, memory latency 3.
        grant("t1", 1, 64'h100, 0, 0, 0, 1, 0);
        f_en_i = 0;
        serve("t1", 64'h100, 3, 32'h0000_0013, -1, 1, 0);
        @(negedge clk);
        chk("t1.busy_after", f_busy_o, 0);
        chk("t1.rdy_after", f_rdy_o, 0);
        tick();

        // Tie after reset: F, then A, then F while both keep requesting.
        do_reset();
        grant("tie1", 1, 64'h0, 1, 64'h800, 0, 1, 0);
        serve("tie1", 64'h0, 1, 32'hAAAA_0001, -1, 1, 0);
        grant("tie2", 1, 64'h0, 1, 64'h800, 0, 0, 1);
        serve("tie2", 64'h800, 2, 32'hBBBB_0002, -1, 0, 1);
        grant("tie3", 1, 64'h0, 1, 64'h800, 0, 1, 0);
        f_en_i = 0; a_en_i = 0;
        serve("tie3", 64'h0, 1, 32'hCCCC_0003, -1, 1, 0);

        // Flush mid-WAIT squashes the fetch response; next fetch is normal.
        grant("fl1", 1, 64'h40, 0, 0, 0, 1, 0);
        f_en_i = 0;
        serve("fl1", 64'h40, 3, 32'hDEAD_0040, 0, 0, 0);
        grant("fl2", 1, 64'h200, 0, 0, 0, 1, 0);
        f_en_i = 0;
        serve("fl2", 64'h200, 2, 32'h1234_0200, -1, 1, 0);

        // Flush coincident with the fetch response suppresses f_rdy.
        grant("flc", 1, 64'h44, 0, 0, 0, 1, 0);
        f_en_i = 0;
        serve("flc", 64'h44, 2, 32'h5555_0044, 1, 0, 0);

        // Flush while A owns the port has no effect.
        grant("fla", 0, 0, 1, 64'h900, 0, 0, 1);
        a_en_i = 0;
        serve("fla", 64'h900, 3, 32'h0900_0900, 1, 0, 1);

        // Flush in IDLE: blocks an F grant; an A grant proceeds.
        grant("fli_f", 1, 64'h60, 0, 0, 1, 0, 0);
        grant("fli_a", 1, 64'h60, 1, 64'h940, 1, 0, 1);
        f_en_i = 0; a_en_i = 0;
        serve("fli_a", 64'h940, 1, 32'h0000_0940, -1, 0, 1);

        // mem_valid_i during ISSUE is ignored.
        grant("viss", 1, 64'h80, 0, 0, 0, 1, 0);
        f_en_i = 0;
        mem_valid_i = 1; mem_data_i = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("viss.rdy", f_rdy_o | a_rdy_o, 0);
        tick();
        mem_valid_i = 0; mem_data_i = '0;
        @(negedge clk);
        chk("viss.busy", f_busy_o, 1);
        chk("viss.rdy2", f_rdy_o, 0);
        tick();
        mem_valid_i = 1; mem_data_i = 32'h0000_0080;
        @(negedge clk);
        chk("viss.frdy", f_rdy_o, 1);
        chk("viss.fdata", f_data_o, 32'h0000_0080);
        tick();
        mem_valid_i = 0;

        // Reset mid-WAIT, then a stray response two cycles later.
        grant("rw", 1, 64'hC0, 0, 0, 0, 1, 0);
        f_en_i = 0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rw.busy", f_busy_o | a_busy_o, 0);
        tick();
        mem_valid_i = 1; mem_data_i = 32'h0BAD_0BAD;
        @(negedge clk);
        chk("rw.rdy", f_rdy_o | a_rdy_o, 0);
        tick();
        mem_valid_i = 0;
        @(negedge clk);
        chk("rw.busy2", f_busy_o, 0);
        chk("rw.men", mem_en_o, 0);
        tick();

`ifdef IMEM_PORT_ARBITER_TIMEOUT_EN
        // No response: err_o pulses on the 5th WAIT cycle (4 after entry).
        grant("to", 1, 64'h300, 0, 0, 0, 1, 0);
        f_en_i = 0;
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("to.err_early", err_o, 0);
            chk("to.busy", f_busy_o, 1);
            tick();
        end
        @(negedge clk);
        chk("to.err", err_o, 1);
        chk("to.frdy", f_rdy_o, 0);
        tick();
        @(negedge clk);
        chk("to.err_done", err_o, 0);
        chk("to.busy_done", f_busy_o, 0);
        tick();
        // Response on the limit cycle wins over the timeout.
        grant("tol", 1, 64'h304, 0, 0, 0, 1, 0);
        f_en_i = 0;
        serve("tol", 64'h304, 5, 32'h0000_0304, -1, 1, 0);
`else
        // Without the timeout, WAIT holds and err_o stays low.
        grant("nto", 1, 64'h300, 0, 0, 0, 1, 0);
        f_en_i = 0;
        tick();
        for (int k = 0; k < 10; k++) tick();
        @(negedge clk);
        chk("nto.err", err_o, 0);
        chk("nto.busy", f_busy_o, 1);
        tick();
        mem_valid_i = 1; mem_data_i = 32'h0000_0300;
        @(negedge clk);
        chk("nto.frdy", f_rdy_o, 1);
        tick();
        mem_valid_i = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
